// File: rtl/gauss_controller.sv
// Control FSM for the n(n+1)/2 summation datapath: one-hot control word, start/ack
// handshake, saturating cycle/iteration counters, iteration timeout and sticky error flag.
module gauss_controller #(
  parameter int CW       = 32,
  parameter int MAX_ITER = 2**16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ack,
  input  logic          status,
  input  logic          done,
  output logic [3:0]    ctrlword,
  output logic          busy,
  output logic          valid,
  output logic          timeout,
  output logic          err,
  output logic [CW-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_TEST = 3'd2,
    S_ADD  = 3'd3,
    S_INC  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  localparam logic [CW-1:0] MAX_ITER_C = CW'(MAX_ITER);
  localparam logic [CW-1:0] ALL_ONES   = {CW{1'b1}};
  localparam logic [CW-1:0] ONE        = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [3:0] ctrl_of(input state_t s);
    logic [3:0] c;
    case (s)
      S_INIT:  c = 4'b0001;
      S_ADD:   c = 4'b0010;
      S_INC:   c = 4'b0100;
      S_OUT:   c = 4'b1000;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  function automatic logic is_run(input state_t s);
    return (s == S_INIT) || (s == S_TEST) || (s == S_ADD) || (s == S_INC);
  endfunction

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == ALL_ONES) ? v : v + ONE;
  endfunction

  state_t        state_r, state_nx;
  logic [CW-1:0] iter_r;
  logic          armed_r;
  logic          accept_s;
  logic          timeout_set_s;
  logic          iter_inc_s;
  logic          mismatch_s;

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nx      = state_r;
    accept_s      = 1'b0;
    timeout_set_s = 1'b0;
    iter_inc_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_nx = S_INIT;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_INIT: state_nx = S_TEST;
      S_TEST: begin
        if (status) begin
          if (iter_r < MAX_ITER_C) begin
            state_nx = S_ADD;
          end else begin
            state_nx      = S_OUT;
            timeout_set_s = 1'b1;
          end
        end else begin
          state_nx = S_OUT;
        end
      end
      S_ADD: begin
        state_nx   = S_INC;
        iter_inc_s = 1'b1;
      end
      S_INC: state_nx = S_TEST;
      S_OUT: begin
        if (ack) begin
          if (start) begin
            accept_s = 1'b1;
            state_nx = S_INIT;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          state_nx = S_OUT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The done check stays quiet only in the IDLE that follows reset, before any run.
  always_comb begin
    mismatch_s = 1'b0;
    if (armed_r || (state_r != S_IDLE)) begin
      mismatch_s = (done != ctrlword[3]);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // State and registered decoded outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      ctrlword <= 4'b0000;
      busy     <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state_r  <= state_nx;
      ctrlword <= ctrl_of(state_nx);
      busy     <= is_run(state_nx);
      valid    <= (state_nx == S_OUT);
    end
  end

  // Run bookkeeping: counters and flags, all cleared when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles  <= {CW{1'b0}};
      iter_r  <= {CW{1'b0}};
      timeout <= 1'b0;
      err     <= 1'b0;
      armed_r <= 1'b0;
    end else if (accept_s) begin
      cycles  <= {CW{1'b0}};
      iter_r  <= {CW{1'b0}};
      timeout <= 1'b0;
      err     <= 1'b0;
      armed_r <= 1'b1;
    end else begin
      cycles  <= is_run(state_r) ? sat_inc(cycles) : cycles;
      iter_r  <= iter_inc_s ? sat_inc(iter_r) : iter_r;
      timeout <= timeout | timeout_set_s;
      err     <= err | mismatch_s;
      armed_r <= armed_r;
    end
  end

endmodule
